// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction-fetch / data memory arbiter.
package mem_arb_pkg;

    localparam int STARVE_MAX_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_D  = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_D  = 1'b1
    } arb_src_t;

    typedef struct packed {
        arb_src_t    src;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
    } arb_txn_t;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of data grants issued while a fetch request is waiting.
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX = STARVE_MAX_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;

    // Clear wins over increment; increment stops at MAX.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != MAX_V)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-outstanding memory port.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | no access in flight; grants are issued combinationally here
//   ST_BUSY_IF | fetch access on the memory port, waiting for mem_ack_i
//   ST_BUSY_D  | data access on the memory port, waiting for mem_ack_i
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_adr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_adr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_adr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    arb_state_t state_q, state_d;
    arb_txn_t   txn_q, txn_d;
    logic       cnt_inc, cnt_clr, at_max;
    logic       busy, busy_if, busy_d;

    assign busy_if = (state_q == ST_BUSY_IF);
    assign busy_d  = (state_q == ST_BUSY_D);
    assign busy    = busy_if || busy_d;

    mem_arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc    (cnt_inc),
        .clr    (cnt_clr),
        .at_max (at_max)
    );

    // State and transaction register; reset abandons any access in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            txn_q   <= txn_d;
        end
    end

    // Arbitration, grants and next state; data has priority unless fetch has starved.
    always_comb begin
        state_d  = state_q;
        txn_d    = txn_q;
        if_gnt_o = 1'b0;
        d_gnt_o  = 1'b0;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rst_i) begin
                    cnt_clr = !if_req_i;
                    if (if_req_i && (!d_req_i || at_max)) begin
                        if_gnt_o    = 1'b1;
                        cnt_clr     = 1'b1;
                        state_d     = ST_BUSY_IF;
                        txn_d.src   = SRC_IF;
                        txn_d.we    = 1'b0;
                        txn_d.adr   = if_adr_i;
                        txn_d.wdata = 32'd0;
                    end else if (d_req_i) begin
                        d_gnt_o     = 1'b1;
                        cnt_inc     = if_req_i;
                        state_d     = ST_BUSY_D;
                        txn_d.src   = SRC_D;
                        txn_d.we    = d_we_i;
                        txn_d.adr   = d_adr_i;
                        txn_d.wdata = d_wdata_i;
                    end
                end
            end
            ST_BUSY_IF, ST_BUSY_D: begin
                if (mem_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Completion pulses and read data capture; write completions leave d_rdata_o untouched.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if_rvalid_o <= 1'b0;
            d_rvalid_o  <= 1'b0;
            if_rdata_o  <= '0;
            d_rdata_o   <= '0;
        end else begin
            if_rvalid_o <= busy_if && mem_ack_i;
            d_rvalid_o  <= busy_d && mem_ack_i;
            if (busy_if && mem_ack_i) begin
                if_rdata_o <= mem_rdata_i;
            end
            if (busy_d && mem_ack_i && !txn_q.we) begin
                d_rdata_o <= mem_rdata_i;
            end
        end
    end

    assign mem_req_o   = busy;
    assign mem_we_o    = busy && txn_q.we;
    assign mem_adr_o   = busy ? txn_q.adr : 32'd0;
    assign mem_wdata_o = busy ? txn_q.wdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory responder, scoreboard monitor and directed scenarios.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int STARVE_MAX = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i, if_gnt_o, if_rvalid_o;
    logic [31:0] if_adr_i, if_rdata_o;
    logic        d_req_i, d_we_i, d_gnt_o, d_rvalid_o;
    logic [31:0] d_adr_i, d_wdata_i, d_rdata_o;
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_adr_o, mem_wdata_o, mem_rdata_i;

    int          n_tests = 0;
    int          n_fail  = 0;
    arb_txn_t    sb[$];
    arb_txn_t    mon_e, mon_p;
    logic [31:0] last_if_rdata = 32'd0;
    logic [31:0] last_d_rdata  = 32'd0;
    logic        mem_auto  = 1'b1;
    logic        man_ack   = 1'b0;
    int          ack_delay = 0;
    int          wait_cnt  = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_adr_i    (if_adr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_adr_i     (d_adr_i),
        .d_wdata_i   (d_wdata_i),
        .d_gnt_o     (d_gnt_o),
        .d_rvalid_o  (d_rvalid_o),
        .d_rdata_o   (d_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_adr_o   (mem_adr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    function automatic logic [31:0] rdata_for(input logic [31:0] adr);
        if (adr == 32'h40) return 32'hE3A0_0005;
        return adr ^ 32'hDEAD_0000;
    endfunction

    // Memory responder: ack after ack_delay wait cycles, read data only valid in the ack cycle.
    always @(negedge clk_i) begin
        if (mem_auto && mem_req_o) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rdata_for(mem_adr_o);
                wait_cnt    = 0;
            end else begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = 32'hBAD0_BAD0;
                wait_cnt    = wait_cnt + 1;
            end
        end else begin
            mem_ack_i   = mem_auto ? 1'b0 : man_ack;
            mem_rdata_i = 32'hBAD0_BAD0;
            wait_cnt    = 0;
        end
    end

    // Scoreboard: push on grant, check memory side while busy, pop and check on rvalid.
    always @(negedge clk_i) begin
        #2;
        if (if_rvalid_o || d_rvalid_o) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_rvalid: if_rvalid=%b d_rvalid=%b, required no completion", if_rvalid_o, d_rvalid_o);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.src == SRC_IF) begin
                    last_if_rdata = rdata_for(mon_e.adr);
                    if (!(if_rvalid_o && !d_rvalid_o) || if_rdata_o !== last_if_rdata) begin
                        n_fail++;
                        $display("FAIL sb_if_completion: if_rvalid=%b d_rvalid=%b if_rdata=%h, required 1 0 %h", if_rvalid_o, d_rvalid_o, if_rdata_o, last_if_rdata);
                    end
                end else begin
                    if (!mon_e.we) last_d_rdata = rdata_for(mon_e.adr);
                    if (!(d_rvalid_o && !if_rvalid_o) || d_rdata_o !== last_d_rdata) begin
                        n_fail++;
                        $display("FAIL sb_d_completion: d_rvalid=%b if_rvalid=%b d_rdata=%h, required 1 0 %h", d_rvalid_o, if_rvalid_o, d_rdata_o, last_d_rdata);
                    end
                end
            end
        end
        if (mem_req_o) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_busy_no_txn: mem_req=1 adr=%h, required no access", mem_adr_o);
            end else if (mem_adr_o !== sb[0].adr || mem_we_o !== sb[0].we || mem_wdata_o !== sb[0].wdata
                         || if_gnt_o !== 1'b0 || d_gnt_o !== 1'b0) begin
                n_fail++;
                $display("FAIL sb_busy: adr=%h we=%b wdata=%h gnt=%b%b, required adr=%h we=%b wdata=%h gnt=00",
                         mem_adr_o, mem_we_o, mem_wdata_o, if_gnt_o, d_gnt_o, sb[0].adr, sb[0].we, sb[0].wdata);
            end
        end
        if (if_gnt_o && d_gnt_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_double_grant: if_gnt=1 d_gnt=1, required at most one");
        end
        if (if_gnt_o) begin
            mon_p.src = SRC_IF; mon_p.we = 1'b0; mon_p.adr = if_adr_i; mon_p.wdata = 32'd0;
            sb.push_back(mon_p);
        end
        if (d_gnt_o) begin
            mon_p.src = SRC_D; mon_p.we = d_we_i; mon_p.adr = d_adr_i; mon_p.wdata = d_wdata_i;
            sb.push_back(mon_p);
        end
    end

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i); #3;
            if (sb.size() == 0 && !mem_req_o) break;
        end
        n_tests++;
        if (sb.size() != 0 || mem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_timeout: pending=%0d mem_req=%b, required 0 0", sb.size(), mem_req_o);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0; if_req_i = 1'b1; d_req_i = 1'b1; if_adr_i = 32'h40; d_adr_i = 32'h64;
        repeat (2) @(negedge clk_i);
        #1;
        n_tests++;
        if (if_gnt_o !== 1'b0 || d_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_grants: if_gnt=%b d_gnt=%b, required 0 0", if_gnt_o, d_gnt_o);
        end
        n_tests++;
        if ({mem_req_o, mem_we_o, mem_adr_o, mem_wdata_o, if_rvalid_o, d_rvalid_o, if_rdata_o, d_rdata_o} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: mem_req=%b adr=%h rvalid=%b%b, required all zero", mem_req_o, mem_adr_o, if_rvalid_o, d_rvalid_o);
        end
        if_req_i = 1'b0; d_req_i = 1'b0; rst_i = 1'b1;
        @(negedge clk_i); #1;
        n_tests++;
        if (mem_req_o !== 1'b0 || if_gnt_o !== 1'b0 || d_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: mem_req=%b gnt=%b%b, required 0 00", mem_req_o, if_gnt_o, d_gnt_o);
        end
    endtask

    task automatic test_lone_fetch();
        @(negedge clk_i); if_req_i = 1'b1; if_adr_i = 32'h40; #1;
        n_tests++;
        if (if_gnt_o !== 1'b1 || d_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL lone_fetch_gnt: if_gnt=%b d_gnt=%b, required 1 0", if_gnt_o, d_gnt_o);
        end
        @(negedge clk_i); if_req_i = 1'b0; #1;
        n_tests++;
        if (mem_req_o !== 1'b1 || mem_adr_o !== 32'h40 || mem_we_o !== 1'b0 || mem_wdata_o !== 32'd0) begin
            n_fail++; $display("FAIL lone_fetch_mem: req=%b adr=%h we=%b wdata=%h, required 1 00000040 0 0", mem_req_o, mem_adr_o, mem_we_o, mem_wdata_o);
        end
        @(negedge clk_i); #1;
        n_tests++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hE3A0_0005) begin
            n_fail++; $display("FAIL lone_fetch_rvalid: rvalid=%b rdata=%h, required 1 e3a00005", if_rvalid_o, if_rdata_o);
        end
        @(negedge clk_i); #1;
        n_tests++;
        if (if_rvalid_o !== 1'b0 || mem_req_o !== 1'b0 || if_rdata_o !== 32'hE3A0_0005) begin
            n_fail++; $display("FAIL lone_fetch_after: rvalid=%b mem_req=%b rdata=%h, required 0 0 e3a00005", if_rvalid_o, mem_req_o, if_rdata_o);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk_i);
        if_req_i = 1'b1; if_adr_i = 32'h80;
        d_req_i = 1'b1; d_we_i = 1'b1; d_adr_i = 32'h64; d_wdata_i = 32'd7;
        #1;
        n_tests++;
        if (d_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL simul_gnt: d_gnt=%b if_gnt=%b, required 1 0", d_gnt_o, if_gnt_o);
        end
        @(negedge clk_i); d_req_i = 1'b0; d_we_i = 1'b0; #1;
        n_tests++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_adr_o !== 32'h64 || mem_wdata_o !== 32'd7 || if_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL simul_write: req=%b we=%b adr=%h wdata=%h if_gnt=%b, required 1 1 00000064 00000007 0",
                               mem_req_o, mem_we_o, mem_adr_o, mem_wdata_o, if_gnt_o);
        end
        @(negedge clk_i); #1;
        n_tests++;
        if (d_rvalid_o !== 1'b1 || if_gnt_o !== 1'b1 || d_rdata_o !== 32'd0) begin
            n_fail++; $display("FAIL simul_b2b: d_rvalid=%b if_gnt=%b d_rdata=%h, required 1 1 0", d_rvalid_o, if_gnt_o, d_rdata_o);
        end
        @(negedge clk_i); if_req_i = 1'b0; #1;
        n_tests++;
        if (mem_req_o !== 1'b1 || mem_adr_o !== 32'h80 || mem_we_o !== 1'b0 || mem_wdata_o !== 32'd0) begin
            n_fail++; $display("FAIL simul_fetch: req=%b adr=%h we=%b wdata=%h, required 1 00000080 0 0", mem_req_o, mem_adr_o, mem_we_o, mem_wdata_o);
        end
        @(negedge clk_i); #1;
        n_tests++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hDEAD_0080) begin
            n_fail++; $display("FAIL simul_fetch_done: rvalid=%b rdata=%h, required 1 dead0080", if_rvalid_o, if_rdata_o);
        end
        drain();
    endtask

    task automatic test_data_rw();
        @(negedge clk_i); d_req_i = 1'b1; d_we_i = 1'b0; d_adr_i = 32'h300; #1;
        n_tests++;
        if (d_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL rw_read_gnt: d_gnt=%b, required 1", d_gnt_o);
        end
        @(negedge clk_i); d_we_i = 1'b1; d_adr_i = 32'h304; d_wdata_i = 32'h1234; #1;
        n_tests++;
        if (d_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL rw_busy_gnt: d_gnt=%b, required 0", d_gnt_o);
        end
        @(negedge clk_i); #1;
        n_tests++;
        if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'hDEAD_0300 || d_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL rw_read_done: rvalid=%b rdata=%h gnt=%b, required 1 dead0300 1", d_rvalid_o, d_rdata_o, d_gnt_o);
        end
        @(negedge clk_i); d_req_i = 1'b0; #1;
        n_tests++;
        if (mem_we_o !== 1'b1 || mem_wdata_o !== 32'h1234 || mem_adr_o !== 32'h304) begin
            n_fail++; $display("FAIL rw_write_mem: we=%b wdata=%h adr=%h, required 1 00001234 00000304", mem_we_o, mem_wdata_o, mem_adr_o);
        end
        @(negedge clk_i); #1;
        n_tests++;
        if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'hDEAD_0300) begin
            n_fail++; $display("FAIL rw_write_done: rvalid=%b rdata=%h, required 1 dead0300", d_rvalid_o, d_rdata_o);
        end
        drain();
    endtask

    task automatic test_starvation();
        int       sc     = 0;
        int       grants = 0;
        logic     adv    = 1'b0;
        arb_src_t exp_src, got_src;
        @(negedge clk_i);
        if_req_i = 1'b1; if_adr_i = 32'h44;
        d_req_i = 1'b1; d_we_i = 1'b0; d_adr_i = 32'h100;
        for (int cyc = 0; cyc < 100 && grants < 10; cyc++) begin
            #1;
            adv = 1'b0;
            if (if_gnt_o || d_gnt_o) begin
                exp_src = (sc == STARVE_MAX) ? SRC_IF : SRC_D;
                got_src = if_gnt_o ? SRC_IF : SRC_D;
                n_tests++;
                if (got_src !== exp_src || (if_gnt_o && d_gnt_o)) begin
                    n_fail++; $display("FAIL starve_order grant %0d: if_gnt=%b d_gnt=%b, required src %0d", grants, if_gnt_o, d_gnt_o, exp_src);
                end
                sc     = (exp_src == SRC_IF) ? 0 : ((sc < STARVE_MAX) ? sc + 1 : sc);
                adv    = d_gnt_o;
                grants = grants + 1;
            end
            @(negedge clk_i);
            if (adv) d_adr_i = d_adr_i + 32'd4;
        end
        n_tests++;
        if (grants != 10) begin
            n_fail++; $display("FAIL starve_timeout: grants=%0d, required 10", grants);
        end
        if_req_i = 1'b0; d_req_i = 1'b0;
        drain();
    endtask

    task automatic test_wait_states();
        int rvc = 0;
        ack_delay = 3;
        @(negedge clk_i); d_req_i = 1'b1; d_we_i = 1'b0; d_adr_i = 32'h200; #1;
        n_tests++;
        if (d_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL wait_gnt: d_gnt=%b, required 1", d_gnt_o);
        end
        @(negedge clk_i); d_req_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) begin if_req_i = 1'b1; if_adr_i = 32'h48; end
            #1;
            n_tests++;
            if (mem_req_o !== 1'b1 || mem_adr_o !== 32'h200 || if_gnt_o !== 1'b0 || d_gnt_o !== 1'b0 || d_rvalid_o !== 1'b0) begin
                n_fail++; $display("FAIL wait_hold cycle %0d: req=%b adr=%h gnt=%b%b rvalid=%b, required 1 00000200 00 0",
                                   c, mem_req_o, mem_adr_o, if_gnt_o, d_gnt_o, d_rvalid_o);
            end
            @(negedge clk_i);
        end
        #1;
        n_tests++;
        if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'hDEAD_0200 || if_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL wait_done: rvalid=%b rdata=%h if_gnt=%b, required 1 dead0200 1", d_rvalid_o, d_rdata_o, if_gnt_o);
        end
        rvc = d_rvalid_o ? 1 : 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            if (c == 0) if_req_i = 1'b0;
            #1;
            if (d_rvalid_o) rvc++;
        end
        n_tests++;
        if (rvc != 1) begin
            n_fail++; $display("FAIL wait_single_pulse: d_rvalid pulses=%0d, required 1", rvc);
        end
        drain();
        ack_delay = 0;
    endtask

    task automatic test_reset_mid_op();
        mem_auto = 1'b0; man_ack = 1'b0;
        @(negedge clk_i); d_req_i = 1'b1; d_we_i = 1'b0; d_adr_i = 32'h400; #1;
        n_tests++;
        if (d_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_gnt: d_gnt=%b, required 1", d_gnt_o);
        end
        @(negedge clk_i); d_req_i = 1'b0; #1;
        n_tests++;
        if (mem_req_o !== 1'b1 || mem_adr_o !== 32'h400) begin
            n_fail++; $display("FAIL rstmid_busy: req=%b adr=%h, required 1 00000400", mem_req_o, mem_adr_o);
        end
        @(negedge clk_i); rst_i = 1'b0; if_req_i = 1'b1; if_adr_i = 32'h50; #1;
        n_tests++;
        if (if_gnt_o !== 1'b0 || d_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_gnt_forced: gnt=%b%b, required 00", if_gnt_o, d_gnt_o);
        end
        @(negedge clk_i);
        sb.delete(); last_if_rdata = 32'd0; last_d_rdata = 32'd0;
        rst_i = 1'b1; if_req_i = 1'b0;
        #1;
        n_tests++;
        if ({mem_req_o, mem_we_o, mem_adr_o, mem_wdata_o, if_rvalid_o, d_rvalid_o, if_rdata_o, d_rdata_o} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: mem_req=%b adr=%h rvalid=%b%b rdata=%h/%h, required all zero",
                               mem_req_o, mem_adr_o, if_rvalid_o, d_rvalid_o, if_rdata_o, d_rdata_o);
        end
        man_ack = 1'b1;
        @(negedge clk_i); #1;
        n_tests++;
        if (mem_req_o !== 1'b0 || d_rvalid_o !== 1'b0 || if_rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_ack_idle: mem_req=%b rvalid=%b%b, required 0 00", mem_req_o, if_rvalid_o, d_rvalid_o);
        end
        man_ack = 1'b0;
        @(negedge clk_i); #1;
        n_tests++;
        if (mem_req_o !== 1'b0 || d_rvalid_o !== 1'b0 || if_rvalid_o !== 1'b0 || d_rdata_o !== 32'd0) begin
            n_fail++; $display("FAIL rstmid_late_ack: mem_req=%b rvalid=%b%b d_rdata=%h, required 0 00 0", mem_req_o, if_rvalid_o, d_rvalid_o, d_rdata_o);
        end
        mem_auto = 1'b1;
    endtask

    task automatic test_withdrawn();
        int dg = 0;
        int drv = 0;
        int dadr = 0;
        ack_delay = 2;
        @(negedge clk_i); if_req_i = 1'b1; if_adr_i = 32'h4C; #1;
        n_tests++;
        if (if_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL withdraw_if_gnt: if_gnt=%b, required 1", if_gnt_o);
        end
        @(negedge clk_i);
        if_req_i = 1'b0; d_req_i = 1'b1; d_we_i = 1'b1; d_adr_i = 32'h500; d_wdata_i = 32'h55;
        #1;
        n_tests++;
        if (d_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL withdraw_busy_gnt: d_gnt=%b, required 0", d_gnt_o);
        end
        @(negedge clk_i); d_req_i = 1'b0; d_we_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (d_gnt_o) dg++;
            if (d_rvalid_o) drv++;
            if (mem_req_o && mem_adr_o == 32'h500) dadr++;
            @(negedge clk_i);
        end
        n_tests++;
        if (dg != 0 || drv != 0 || dadr != 0) begin
            n_fail++; $display("FAIL withdraw_no_data: d_gnt=%0d d_rvalid=%0d data_access=%0d, required 0 0 0", dg, drv, dadr);
        end
        n_tests++;
        if (if_rdata_o !== 32'hDEAD_004C) begin
            n_fail++; $display("FAIL withdraw_fetch_data: if_rdata=%h, required dead004c", if_rdata_o);
        end
        drain();
        ack_delay = 0;
    endtask

    initial begin
        rst_i = 1'b0;
        if_req_i = 1'b0; if_adr_i = 32'd0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_adr_i = 32'd0; d_wdata_i = 32'd0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_data_rw();
        test_starvation();
        test_wait_states();
        test_reset_mid_op();
        test_withdrawn();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "bench did not complete");
    end

endmodule
